seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range is 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the rising clk edge.
REQ-005 SHALL have port a, input, WIDTH bits: unsigned multiplicand, sampled with start.
REQ-006 SHALL have port b, input, WIDTH bits: unsigned multiplier, sampled with start.
REQ-007 SHALL have port ready, output, 1 bit: high when a start will be accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse marking product valid.
REQ-010 SHALL have port product, output, 2*WIDTH bits: unsigned a*b result.

Function
REQ-011 SHALL implement an FSM with exactly three states: IDLE, BUSY and DONE.
REQ-012 SHALL set ready=1 in IDLE and DONE, and ready=0 in BUSY.
REQ-013 SHALL set busy=1 only in BUSY, and done=1 only in DONE.
REQ-014 SHALL, on an edge where start=1 and ready=1, latch a into the multiplicand register, load {upper WIDTH bits = 0, lower WIDTH bits = b} into the accumulator, clear the step counter, and enter BUSY.
REQ-015 SHALL, on each BUSY edge, do one step: if accumulator bit 0 is 1, add the multiplicand into the upper WIDTH bits as a (WIDTH+1)-bit sum with carry; otherwise add 0.
REQ-016 SHALL, in the same step, shift {carry, upper, lower} right by one bit into the 2*WIDTH-bit accumulator, then increment the step counter.
REQ-017 SHALL take exactly WIDTH BUSY cycles, then enter DONE on the edge that completes step WIDTH.
REQ-018 SHALL, with start accepted at edge E0, raise done during the cycle after edge E_WIDTH, for exactly one cycle.
REQ-019 SHALL drive product from the accumulator only at DONE entry, and hold that value until the next DONE entry or reset; product SHALL NOT change during BUSY.
REQ-020 SHALL, in DONE with start=0, go to IDLE on the next edge.
REQ-021 SHALL, in DONE with start=1, accept the new operands and go directly to BUSY (back-to-back operation, no idle cycle).
REQ-022 SHALL ignore start while in BUSY: no operand latch and no restart, and the current operation SHALL be unaffected.
REQ-023 SHALL ignore changes on a and b outside an accepting edge.
REQ-024 SHALL give the exact unsigned result; overflow is impossible at 2*WIDTH bits, e.g. (2^WIDTH-1)^2 SHALL fit.
REQ-025 SHALL size the step counter at ceil(log2(WIDTH+1)) bits or more, with no wrap before reaching WIDTH.
REQ-026 SHALL contain no combinational path from start, a or b to any output.

Reset
REQ-027 SHALL, on an edge with reset=1, force IDLE, set product=0 and clear the accumulator, multiplicand register and counter; ready=1, busy=0 and done=0 SHALL hold in the next cycle.
REQ-028 SHALL give reset priority over start on the same edge.
REQ-029 SHALL, on reset mid-operation (BUSY), abandon the operation with no done pulse.

Verification
REQ-030 SHALL cover a basic multiply: WIDTH=8, a=3, b=5, start for one cycle -> busy for 8 cycles, then done for 1 cycle with product=15, then IDLE.
REQ-031 SHALL cover the maximum operands: a=255, b=255 -> product=65025 (0xFE01) with done 9 cycles after the start edge.
REQ-032 SHALL cover zero and identity: a=0, b=200 gives product=0; a=1, b=200 gives product=200; the previous product SHALL be held until each new done.
REQ-033 SHALL cover start while busy: start a=7, b=9, then pulse start with a=2, b=2 at BUSY cycle 3 -> a single done, product=63, and no extra busy cycles.
REQ-034 SHALL cover reset mid-operation: reset=1 at BUSY cycle 4 -> next cycle shows ready=1, busy=0, done=0, product=0, and no done pulse follows.
REQ-035 SHALL cover back-to-back operation: start=1 held through DONE with a=12, b=11 after a 6x7 multiply -> done with product=42, then BUSY immediately, then done with product=132.

Source files
------------

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Unsigned shift-and-add multiplier. One partial-product step
//               per clock, WIDTH steps per multiply, registered product with
//               a one-cycle done pulse and back-to-back start from DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Counter wide enough to hold WIDTH itself, so it never wraps early.
  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last_step;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_step;

  // Start is only honoured outside BUSY; the final step is when the
  // counter has already completed WIDTH-1 steps.
  assign w_accept    = start && (r_state != S_BUSY);
  assign w_last_step = (r_state == S_BUSY) && (r_cnt == C_LAST);

  // One shift-and-add step: conditional add into the upper half with carry,
  // then shift {carry, upper, lower} right by one.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_acc_step = {w_sum, r_acc[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_BUSY;
      S_BUSY:  if (w_last_step) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_BUSY : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand load on accept, one step per BUSY cycle, product
  // captured only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= a;
      r_acc   <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last_step) begin
        r_product <= w_acc_step;
      end
    end
  end

  // Status outputs depend only on state, so no input reaches an output
  // combinationally.
  assign ready   = (r_state != S_BUSY);
  assign busy    = (r_state == S_BUSY);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Directed bench for seq_multiplier (WIDTH=8). A cycle-level
//               behavioural model (phase + remaining-cycle count, product
//               from plain a*b) is compared every cycle, and hand-computed
//               literals pin key results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_vec;
  int n_err;
  bit chk_en;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: 0 = idle, 1 = busy, 2 = done.
  int                 m_phase;
  int                 m_rem;
  logic [2*WIDTH-1:0] m_pending;
  logic [2*WIDTH-1:0] m_prod;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_prod  <= '0;
    end else if (m_phase == 1) begin
      if (m_rem == 1) begin
        m_phase <= 2;
        m_prod  <= m_pending;
      end
      m_rem <= m_rem - 1;
    end else if (start) begin
      m_pending <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
      m_rem     <= WIDTH;
      m_phase   <= 1;
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec = n_vec + 4;
      if (ready !== (m_phase != 0 ? (m_phase != 1) : 1'b1)) begin
        n_err = n_err + 1;
        $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready, m_phase != 1);
      end
      if (busy !== (m_phase == 1)) begin
        n_err = n_err + 1;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_phase == 1);
      end
      if (done !== (m_phase == 2)) begin
        n_err = n_err + 1;
        $display("FAIL model_done t=%0t got=%b exp=%b", $time, done, m_phase == 2);
      end
      if (product !== m_prod) begin
        n_err = n_err + 1;
        $display("FAIL model_product t=%0t got=%0d exp=%0d", $time, product, m_prod);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns at the negedge of BUSY cycle 1.
  task automatic go(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cyc(2);
    chk_en = 1'b1;
    check_lit("rst_ready", 32'(ready), 32'd1);
    check_lit("rst_busy", 32'(busy), 32'd0);
    check_lit("rst_done", 32'(done), 32'd0);
    check_lit("rst_product", 32'(product), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Basic 3*5: busy for 8 cycles, done on the 9th, then idle.
    go(8'd3, 8'd5);
    check_lit("b3x5_busy_c1", 32'(busy), 32'd1);
    cyc(7);
    check_lit("b3x5_busy_c8", 32'(busy), 32'd1);
    cyc(1);
    check_lit("b3x5_done", 32'(done), 32'd1);
    check_lit("b3x5_product", 32'(product), 32'd15);
    cyc(1);
    check_lit("b3x5_idle_done", 32'(done), 32'd0);
    check_lit("b3x5_idle_ready", 32'(ready), 32'd1);

    // Maximum operands.
    go(8'd255, 8'd255);
    cyc(8);
    check_lit("max_done", 32'(done), 32'd1);
    check_lit("max_product", 32'(product), 32'hFE01);
    cyc(2);

    // Zero and identity, previous product held during BUSY.
    go(8'd0, 8'd200);
    cyc(4);
    check_lit("zero_hold_prev", 32'(product), 32'hFE01);
    cyc(4);
    check_lit("zero_product", 32'(product), 32'd0);
    cyc(1);
    go(8'd1, 8'd200);
    cyc(4);
    check_lit("ident_hold_prev", 32'(product), 32'd0);
    cyc(4);
    check_lit("ident_product", 32'(product), 32'd200);
    cyc(2);

    // Start while busy is ignored.
    go(8'd7, 8'd9);
    cyc(2);
    a = 8'd2; b = 8'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    check_lit("sib_done", 32'(done), 32'd1);
    check_lit("sib_product", 32'(product), 32'd63);
    cyc(1);
    check_lit("sib_no_extra_busy", 32'(busy), 32'd0);
    cyc(1);
    check_lit("sib_no_extra_busy2", 32'(busy), 32'd0);

    // Reset mid-operation at BUSY cycle 4, with start also high.
    go(8'd13, 8'd17);
    cyc(3);
    reset = 1'b1;
    start = 1'b1;
    cyc(1);
    reset = 1'b0;
    start = 1'b0;
    check_lit("rmid_ready", 32'(ready), 32'd1);
    check_lit("rmid_busy", 32'(busy), 32'd0);
    check_lit("rmid_done", 32'(done), 32'd0);
    check_lit("rmid_product", 32'(product), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check_lit("rmid_no_done", 32'(done), 32'd0);
    end

    // Back-to-back: start held through DONE.
    go(8'd6, 8'd7);
    cyc(7);
    a = 8'd12; b = 8'd11; start = 1'b1;
    cyc(1);
    check_lit("b2b_done1", 32'(done), 32'd1);
    check_lit("b2b_product1", 32'(product), 32'd42);
    cyc(1);
    start = 1'b0;
    a = 8'd0; b = 8'd0;
    check_lit("b2b_busy_again", 32'(busy), 32'd1);
    check_lit("b2b_hold42", 32'(product), 32'd42);
    cyc(8);
    check_lit("b2b_done2", 32'(done), 32'd1);
    check_lit("b2b_product2", 32'(product), 32'd132);
    cyc(2);

    // A few more patterns checked by the model only.
    go(8'd170, 8'd85);  cyc(10);
    go(8'd128, 8'd2);   cyc(10);
    go(8'd37, 8'd0);    cyc(10);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
